// File: rtl/key_conditioner.sv
// key_conditioner: push-button front end for the hex-counter / 7-segment scan block.
// Each key channel runs its own 2-flop synchronizer, debounce counter and an
// optional hold-to-auto-repeat FSM, producing clean 1-cycle press/release pulses.
module key_conditioner #(
   parameter int N_KEYS          = 2,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_RATE     = 5000000,
   parameter int ACTIVE_LOW      = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [N_KEYS-1:0] keys_in,
   input  logic [N_KEYS-1:0] repeat_en,
   output logic [N_KEYS-1:0] key_level,
   output logic [N_KEYS-1:0] press_pulse,
   output logic [N_KEYS-1:0] repeat_flag,
   output logic [N_KEYS-1:0] release_pulse
);

   // One counter width covers every timing phase; the extra bit keeps the
   // largest terminal count representable without wrapping.
   localparam int MAX_A   = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
   localparam int MAX_CYC = (MAX_A > REPEAT_RATE) ? MAX_A : REPEAT_RATE;
   localparam int CW      = $clog2(MAX_CYC) + 1;

   localparam logic [CW-1:0] DB_C    = CW'(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] RD_M1   = CW'(REPEAT_DELAY - 1);
   localparam logic [CW-1:0] RR_M1   = CW'(REPEAT_RATE - 1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic          INV     = (ACTIVE_LOW != 0);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRESS_WAIT,
      ST_HELD,
      ST_REPEAT,
      ST_RELEASE_WAIT
   } state_t;

   genvar gi;
   generate
      for (gi = 0; gi < N_KEYS; gi++) begin : g_key
         logic          s1_reg;
         logic          s2_reg;
         state_t        state_reg;
         logic [CW-1:0] cnt_reg;
         logic          level_reg;
         logic          press_reg;
         logic          flag_reg;
         logic          release_reg;
         logic          key_raw;

         // Polarity is normalised before synchronizing so reset = released.
         assign key_raw = keys_in[gi] ^ INV;

         // Two-flop synchronizer; only s2 feeds the FSM.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               s1_reg <= 1'b0;
               s2_reg <= 1'b0;
            end else begin
               s1_reg <= key_raw;
               s2_reg <= s1_reg;
            end
         end

         // Debounce / hold / auto-repeat FSM with registered pulse outputs.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               state_reg   <= ST_IDLE;
               cnt_reg     <= '0;
               level_reg   <= 1'b0;
               press_reg   <= 1'b0;
               flag_reg    <= 1'b0;
               release_reg <= 1'b0;
            end else begin
               press_reg   <= 1'b0;
               flag_reg    <= 1'b0;
               release_reg <= 1'b0;
               case (state_reg)
                  ST_IDLE: begin
                     if (s2_reg) begin
                        state_reg <= ST_PRESS_WAIT;
                        cnt_reg   <= CNT_ONE;
                     end
                  end
                  ST_PRESS_WAIT: begin
                     if (!s2_reg) begin
                        state_reg <= ST_IDLE;
                        cnt_reg   <= '0;
                     end else if (cnt_reg == DB_C) begin
                        state_reg <= ST_HELD;
                        press_reg <= 1'b1;
                        level_reg <= 1'b1;
                        cnt_reg   <= '0;
                     end else begin
                        cnt_reg <= cnt_reg + CNT_ONE;
                     end
                  end
                  ST_HELD: begin
                     if (!s2_reg) begin
                        state_reg <= ST_RELEASE_WAIT;
                        cnt_reg   <= CNT_ONE;
                     end else if (repeat_en[gi] && (cnt_reg >= RD_M1)) begin
                        state_reg <= ST_REPEAT;
                        press_reg <= 1'b1;
                        flag_reg  <= 1'b1;
                        cnt_reg   <= '0;
                     end else if (cnt_reg < RD_M1) begin
                        // Stops at the delay threshold so a late repeat_en fires next cycle.
                        cnt_reg <= cnt_reg + CNT_ONE;
                     end
                  end
                  ST_REPEAT: begin
                     if (!s2_reg) begin
                        state_reg <= ST_RELEASE_WAIT;
                        cnt_reg   <= CNT_ONE;
                     end else if (!repeat_en[gi]) begin
                        state_reg <= ST_HELD;
                        cnt_reg   <= '0;
                     end else if (cnt_reg == RR_M1) begin
                        press_reg <= 1'b1;
                        flag_reg  <= 1'b1;
                        cnt_reg   <= '0;
                     end else begin
                        cnt_reg <= cnt_reg + CNT_ONE;
                     end
                  end
                  ST_RELEASE_WAIT: begin
                     if (s2_reg) begin
                        // Release bounce: back to held and restart the repeat timer.
                        state_reg <= ST_HELD;
                        cnt_reg   <= '0;
                     end else if (cnt_reg == DB_C) begin
                        state_reg   <= ST_IDLE;
                        release_reg <= 1'b1;
                        level_reg   <= 1'b0;
                        cnt_reg     <= '0;
                     end else begin
                        cnt_reg <= cnt_reg + CNT_ONE;
                     end
                  end
                  default: begin
                     state_reg <= ST_IDLE;
                     cnt_reg   <= '0;
                  end
               endcase
            end
         end

         assign key_level[gi]     = level_reg;
         assign press_pulse[gi]   = press_reg;
         assign repeat_flag[gi]   = flag_reg;
         assign release_pulse[gi] = release_reg;
      end
   endgenerate

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner: small timing parameters, one task per
// scenario, cycle-by-cycle comparison against hand-computed pulse positions.
// Edge index 0 is the first rising clock edge after an input change.
module tb_key_conditioner;
   localparam int NK = 2;

   logic          clk;
   logic          rst_n;
   logic [NK-1:0] keys;
   logic [NK-1:0] rep;
   logic [NK-1:0] key_level, press_pulse, repeat_flag, release_pulse;
   logic [NK-1:0] keys_al;
   logic [NK-1:0] key_level_al, press_pulse_al, repeat_flag_al, release_pulse_al;

   int total;
   int bad;

   key_conditioner #(
      .N_KEYS(NK), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_RATE(8), .ACTIVE_LOW(0)
   ) u_dut (
      .clk(clk), .rst_n(rst_n), .keys_in(keys), .repeat_en(rep),
      .key_level(key_level), .press_pulse(press_pulse),
      .repeat_flag(repeat_flag), .release_pulse(release_pulse)
   );

   key_conditioner #(
      .N_KEYS(NK), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_RATE(8), .ACTIVE_LOW(1)
   ) u_al (
      .clk(clk), .rst_n(rst_n), .keys_in(keys_al), .repeat_en(2'b00),
      .key_level(key_level_al), .press_pulse(press_pulse_al),
      .repeat_flag(repeat_flag_al), .release_pulse(release_pulse_al)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic apply_reset;
      @(negedge clk);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset;
      logic [7:0] obs;
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      obs = {press_pulse, release_pulse, repeat_flag, key_level};
      total++;
      if (obs !== 8'h00) begin
         bad++;
         $display("FAIL reset_main got=%h want=00", obs);
      end
      obs = {press_pulse_al, release_pulse_al, repeat_flag_al, key_level_al};
      total++;
      if (obs !== 8'h00) begin
         bad++;
         $display("FAIL reset_al got=%h want=00", obs);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         obs = {press_pulse, release_pulse, repeat_flag, key_level,
                press_pulse_al, release_pulse_al, repeat_flag_al, key_level_al};
         total++;
         if (obs !== 8'h00) begin
            bad++;
            $display("FAIL reset_idle cyc=%0d got=%h want=00", i, obs);
         end
      end
      $display("test_reset done");
   endtask

   task automatic test_press_release;
      logic [7:0] obs, exp;
      apply_reset();
      @(negedge clk);
      keys[1] = 1'b1;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk);
         #1;
         obs = {press_pulse, release_pulse, repeat_flag, key_level};
         exp = {(i == 6) ? 2'b10 : 2'b00, 2'b00, 2'b00, (i >= 6) ? 2'b10 : 2'b00};
         total++;
         if (obs !== exp) begin
            bad++;
            $display("FAIL press1 cyc=%0d got=%h want=%h", i, obs, exp);
         end
      end
      @(negedge clk);
      keys[1] = 1'b0;
      for (int j = 0; j < 10; j++) begin
         @(posedge clk);
         #1;
         obs = {press_pulse, release_pulse, repeat_flag, key_level};
         exp = {2'b00, (j == 6) ? 2'b10 : 2'b00, 2'b00, (j < 6) ? 2'b10 : 2'b00};
         total++;
         if (obs !== exp) begin
            bad++;
            $display("FAIL release1 cyc=%0d got=%h want=%h", j, obs, exp);
         end
      end
      $display("test_press_release done");
   endtask

   task automatic test_bounce;
      logic [7:0] obs, exp;
      apply_reset();
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         keys[0] = (c < 8) ? (((c / 2) % 2) == 0) : 1'b1;
         @(posedge clk);
         #1;
         obs = {press_pulse, release_pulse, repeat_flag, key_level};
         exp = {(c == 14) ? 2'b01 : 2'b00, 2'b00, 2'b00, (c >= 14) ? 2'b01 : 2'b00};
         total++;
         if (obs !== exp) begin
            bad++;
            $display("FAIL bounce_press cyc=%0d got=%h want=%h", c, obs, exp);
         end
      end
      @(negedge clk);
      keys[0] = 1'b0;
      for (int j = 0; j < 10; j++) begin
         @(posedge clk);
         #1;
         obs = {press_pulse, release_pulse, repeat_flag, key_level};
         exp = {2'b00, (j == 6) ? 2'b01 : 2'b00, 2'b00, (j < 6) ? 2'b01 : 2'b00};
         total++;
         if (obs !== exp) begin
            bad++;
            $display("FAIL bounce_release cyc=%0d got=%h want=%h", j, obs, exp);
         end
      end
      $display("test_bounce done");
   endtask

   task automatic test_repeat;
      logic [7:0] obs, exp;
      logic       rp, pp;
      apply_reset();
      @(negedge clk);
      rep = 2'b10;
      keys[1] = 1'b1;
      for (int i = 0; i < 60; i++) begin
         @(posedge clk);
         #1;
         rp  = (i == 26) || (i == 34) || (i == 42) || (i == 50) || (i == 58);
         pp  = rp || (i == 6);
         obs = {press_pulse, release_pulse, repeat_flag, key_level};
         exp = {pp, 1'b0, 2'b00, rp, 1'b0, (i >= 6), 1'b0};
         total++;
         if (obs !== exp) begin
            bad++;
            $display("FAIL repeat cyc=%0d got=%h want=%h", i, obs, exp);
         end
      end
      @(negedge clk);
      keys[1] = 1'b0;
      for (int j = 0; j < 10; j++) begin
         @(posedge clk);
         #1;
         obs = {press_pulse, release_pulse, repeat_flag, key_level};
         exp = {2'b00, (j == 6) ? 2'b10 : 2'b00, 2'b00, (j < 6) ? 2'b10 : 2'b00};
         total++;
         if (obs !== exp) begin
            bad++;
            $display("FAIL repeat_release cyc=%0d got=%h want=%h", j, obs, exp);
         end
      end
      rep = 2'b00;
      $display("test_repeat done");
   endtask

   task automatic test_simultaneous;
      logic [7:0] obs, exp;
      apply_reset();
      @(negedge clk);
      keys = 2'b11;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk);
         #1;
         obs = {press_pulse, release_pulse, repeat_flag, key_level};
         exp = {(i == 6) ? 2'b11 : 2'b00, 2'b00, 2'b00, (i >= 6) ? 2'b11 : 2'b00};
         total++;
         if (obs !== exp) begin
            bad++;
            $display("FAIL simul_press cyc=%0d got=%h want=%h", i, obs, exp);
         end
      end
      // key0 release bounce: low 2, high 2, then low; key1 stays held.
      for (int c = 0; c < 14; c++) begin
         @(negedge clk);
         keys[0] = (c == 2) || (c == 3);
         @(posedge clk);
         #1;
         obs = {press_pulse, release_pulse, repeat_flag, key_level};
         exp = {2'b00, (c == 10) ? 2'b01 : 2'b00, 2'b00, (c < 10) ? 2'b11 : 2'b10};
         total++;
         if (obs !== exp) begin
            bad++;
            $display("FAIL simul_bounce cyc=%0d got=%h want=%h", c, obs, exp);
         end
      end
      @(negedge clk);
      keys[1] = 1'b0;
      for (int j = 0; j < 10; j++) begin
         @(posedge clk);
         #1;
         obs = {press_pulse, release_pulse, repeat_flag, key_level};
         exp = {2'b00, (j == 6) ? 2'b10 : 2'b00, 2'b00, (j < 6) ? 2'b10 : 2'b00};
         total++;
         if (obs !== exp) begin
            bad++;
            $display("FAIL simul_release1 cyc=%0d got=%h want=%h", j, obs, exp);
         end
      end
      $display("test_simultaneous done");
   endtask

   task automatic test_reset_mid_hold;
      logic [7:0] obs, exp;
      apply_reset();
      @(negedge clk);
      rep = 2'b10;
      keys[1] = 1'b1;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk);
         #1;
         obs = {press_pulse, release_pulse, repeat_flag, key_level};
         exp = {(i == 6 || i == 26) ? 2'b10 : 2'b00, 2'b00,
                (i == 26) ? 2'b10 : 2'b00, (i >= 6) ? 2'b10 : 2'b00};
         total++;
         if (obs !== exp) begin
            bad++;
            $display("FAIL midhold_pre cyc=%0d got=%h want=%h", i, obs, exp);
         end
      end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      obs = {press_pulse, release_pulse, repeat_flag, key_level};
      total++;
      if (obs !== 8'h00) begin
         bad++;
         $display("FAIL midhold_async got=%h want=00", obs);
      end
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         obs = {press_pulse, release_pulse, repeat_flag, key_level};
         total++;
         if (obs !== 8'h00) begin
            bad++;
            $display("FAIL midhold_inreset cyc=%0d got=%h want=00", k, obs);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 16; i++) begin
         @(posedge clk);
         #1;
         obs = {press_pulse, release_pulse, repeat_flag, key_level};
         exp = {(i == 6) ? 2'b10 : 2'b00, 2'b00, 2'b00, (i >= 6) ? 2'b10 : 2'b00};
         total++;
         if (obs !== exp) begin
            bad++;
            $display("FAIL midhold_post cyc=%0d got=%h want=%h", i, obs, exp);
         end
      end
      @(negedge clk);
      keys[1] = 1'b0;
      rep = 2'b00;
      for (int j = 0; j < 10; j++) begin
         @(posedge clk);
         #1;
         obs = {press_pulse, release_pulse, repeat_flag, key_level};
         exp = {2'b00, (j == 6) ? 2'b10 : 2'b00, 2'b00, (j < 6) ? 2'b10 : 2'b00};
         total++;
         if (obs !== exp) begin
            bad++;
            $display("FAIL midhold_release cyc=%0d got=%h want=%h", j, obs, exp);
         end
      end
      $display("test_reset_mid_hold done");
   endtask

   task automatic test_active_low;
      logic [7:0] obs, exp;
      apply_reset();
      @(negedge clk);
      keys_al[0] = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1;
         obs = {press_pulse_al, release_pulse_al, repeat_flag_al, key_level_al};
         exp = {(i == 6) ? 2'b01 : 2'b00, 2'b00, 2'b00, (i >= 6) ? 2'b01 : 2'b00};
         total++;
         if (obs !== exp) begin
            bad++;
            $display("FAIL actlow_press cyc=%0d got=%h want=%h", i, obs, exp);
         end
      end
      @(negedge clk);
      keys_al[0] = 1'b1;
      for (int j = 0; j < 10; j++) begin
         @(posedge clk);
         #1;
         obs = {press_pulse_al, release_pulse_al, repeat_flag_al, key_level_al};
         exp = {2'b00, (j == 6) ? 2'b01 : 2'b00, 2'b00, (j < 6) ? 2'b01 : 2'b00};
         total++;
         if (obs !== exp) begin
            bad++;
            $display("FAIL actlow_release cyc=%0d got=%h want=%h", j, obs, exp);
         end
      end
      $display("test_active_low done");
   endtask

   initial begin
      total   = 0;
      bad     = 0;
      keys    = 2'b00;
      rep     = 2'b00;
      keys_al = 2'b11;
      rst_n   = 1'b1;
      #1;
      rst_n   = 1'b0;
      test_reset();
      test_press_release();
      test_bounce();
      test_repeat();
      test_simultaneous();
      test_reset_mid_hold();
      test_active_low();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
